// File: rtl/inst_rom.sv
// Instruction ROM with a byte-serial boot loader: holds the CPU in reset while an image
// streams in big-endian, then serves zero-latency combinational instruction fetches.
module inst_rom #(
    parameter int unsigned ADDR_W  = 10,
    parameter bit          BOOT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [31:0]       addr,
    output logic [31:0]       inst_o,
    input  logic              load_valid_i,
    input  logic [7:0]        load_byte_i,
    input  logic              load_last_i,
    output logic              load_ready_o,
    output logic              cpu_rst_o,
    output logic [ADDR_W:0]   words_loaded_o
);

    localparam int unsigned Depth = 1 << ADDR_W;
    localparam logic [ADDR_W:0] PtrOne = 1;

    typedef enum logic {StBoot, StRun} state_e;

    state_e            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       asm_q, asm_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;

    logic [31:0]       mem [Depth];

    logic              accept;
    logic              wr_en;
    logic              full;
    logic [31:0]       asm_shift;
    logic [31:0]       wr_word;

    // Only the word-index bits of the byte address select a word.
    logic unused_addr;
    assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

    always_comb begin
        accept    = !rst && load_valid_i && (state_q == StBoot);
        asm_shift = {asm_q[23:0], load_byte_i};
        // A short final word is left-justified with zero padding below.
        case (byte_cnt_q)
            2'd0:    wr_word = {load_byte_i, 24'h0};
            2'd1:    wr_word = {asm_q[7:0], load_byte_i, 16'h0};
            2'd2:    wr_word = {asm_q[15:0], load_byte_i, 8'h0};
            default: wr_word = asm_shift;
        endcase
        wr_en = accept && (load_last_i || (byte_cnt_q == 2'd3));
        full  = (ptr_q[ADDR_W-1:0] == '1);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT_EN ? StBoot : StRun;
            byte_cnt_q <= 2'd0;
            asm_q      <= 32'h0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            ptr_q      <= ptr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        ptr_d      = ptr_q;
        if (accept) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            asm_d      = asm_shift;
        end
        if (wr_en) begin
            ptr_d = ptr_q + PtrOne;
            // Filling the last word ends boot so word 0 is never overwritten.
            if (load_last_i || full) begin
                state_d = StRun;
            end
        end
    end

    // Memory is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr_q[ADDR_W-1:0]] <= wr_word;
        end
    end

    // Outputs
    always_comb begin
        load_ready_o   = (state_q == StBoot);
        cpu_rst_o      = (state_q == StBoot);
        words_loaded_o = ptr_q;
        inst_o         = 32'h0;
        if (ce && !rst && (state_q == StRun)) begin
            inst_o = mem[addr[ADDR_W+1:2]];
        end
    end

endmodule

// File: doc/inst_rom.md
INST_ROM -- requirements
Module: inst_rom

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width; ROM depth is 2^ADDR_W 32-bit words.
REQ-002 Parameter BOOT_EN, default 1, 1 = boot loader active after reset; 0 = start directly in RUN with cpu_rst_o low.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ce  input  1  read enable from pc_reg.
REQ-006 addr  input  32  byte address of the instruction from pc_reg.
REQ-007 inst_o  output  32  instruction word to the CPU.
REQ-008 load_valid_i  input  1  loader byte valid.
REQ-009 load_byte_i  input  8  loader byte, big-endian within each word.
REQ-010 load_last_i  input  1  qualifies the current valid byte as the final image byte.
REQ-011 load_ready_o  output  1  loader may present a byte; a byte transfers when load_valid_i and load_ready_o are both high at a rising edge.
REQ-012 cpu_rst_o  output  1  reset to the CPU core; high while booting.
REQ-013 words_loaded_o  output  ADDR_W+1  count of words written since reset.

Function
REQ-014 States: BOOT (accepting bytes) and RUN (serving fetches); a 2-bit byte counter and an ADDR_W+1-bit word pointer.
REQ-015 In BOOT, load_ready_o is 1 and cpu_rst_o is 1; in RUN, load_ready_o is 0 and cpu_rst_o is 0.
REQ-016 Each accepted byte shifts into a 32-bit assembly register (first byte lands in bits 31:24); the byte counter increments modulo 4.
REQ-017 On the 4th accepted byte, the assembled word is written to mem[pointer] at that edge; the pointer and words_loaded_o increment by 1.
REQ-018 Accepted byte with load_last_i=1: the partial word is left-justified, zero-padded in its low bytes, and written to mem[pointer] (on a 4th byte it is written as normal); words_loaded_o increments; the state goes to RUN at the same edge.
REQ-019 Full: when the write fills word 2^ADDR_W-1, the state goes to RUN at that edge regardless of load_last_i; no wrap-around and no overwrite of word 0.
REQ-020 Bytes with load_valid_i=1 in RUN are ignored; memory and counters are unchanged.
REQ-021 load_last_i is ignored when load_valid_i=0.
REQ-022 Read path is combinational: inst_o = mem[addr[ADDR_W+1:2]] when ce=1 and the state is RUN; otherwise inst_o = 32'h0.
REQ-023 addr[1:0] and addr bits above ADDR_W+1 are ignored; no alignment fault is raised.
REQ-024 Read latency is zero cycles, matching a PC registered at cycle n and an instruction latched by if_id at edge n+1.
REQ-025 Words beyond the loaded image read as their prior contents; memory is never implicitly cleared.

Reset
REQ-026 While rst=1, asynchronously: state = BOOT (RUN if BOOT_EN=0); byte counter, assembly register, pointer and words_loaded_o are 0; cpu_rst_o = 1 (0 if BOOT_EN=0); load_ready_o = 1 (0 if BOOT_EN=0); inst_o = 0.
REQ-027 Memory contents are not affected by rst.
REQ-028 rst asserted mid-word discards the partial word; after release, loading restarts at word 0, byte 0.
REQ-029 rst asserted in RUN returns the block to BOOT (BOOT_EN=1) and re-holds the CPU in reset.

Verification
REQ-030 Bytes 34 01 00 01, 34 02 00 02 (last on 8th byte), then ce=1, addr=0x4 -> inst_o=0x34020002, words_loaded_o=2, cpu_rst_o falls at the edge accepting the 8th byte.
REQ-031 Six bytes AA BB CC DD 11 22 with last on 22 -> mem[1]=0x11220000, RUN entered, words_loaded_o=2.
REQ-032 ADDR_W=2, 16 bytes with no last -> RUN after the 16th byte; a 17th valid byte is ignored; mem[0] is unchanged.
REQ-033 rst pulse after 2 bytes, then 4 bytes 0x01020304 with last -> mem[0]=0x01020304; no remnant of the first 2 bytes.
REQ-034 In RUN with ce=0 and any addr -> inst_o=0; with ce=1, addr=0x7 -> same word as addr=0x4.
REQ-035 BOOT_EN=0: after reset release -> cpu_rst_o=0 and load_ready_o=0 immediately; preloaded memory is readable the same cycle.
